// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: per-channel IDLE/ARMED/RINGING/SNOOZE FSMs compared against the 1 Hz time base.
// Optional macro ALARM_WEEKDAY_MASK_EN adds a per-channel day-of-week enable mask.
module multi_alarm_ctrl #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    localparam int unsigned IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [4:0]            cur_hour,
    input  logic [5:0]            cur_min,
    input  logic [5:0]            cur_sec,
`ifdef ALARM_WEEKDAY_MASK_EN
    input  logic [2:0]            cur_dow,
    input  logic [6:0]            wr_dow_mask,
`endif
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [4:0]            wr_hour,
    input  logic [5:0]            wr_min,
    input  logic                  wr_arm,
    input  logic                  ack,
    input  logic                  snooze,
    output logic [NUM_ALARMS-1:0] ring,
    output logic                  alarm_any,
    output logic [IDX_W-1:0]      active_idx,
    output logic                  wr_err
);

    localparam int unsigned RING_W = 8;
    localparam int unsigned SNZ_W  = 11;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_MIN * 60 - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_e;

    state_e            state_q    [NUM_ALARMS];
    state_e            state_d    [NUM_ALARMS];
    logic [4:0]        hour_q     [NUM_ALARMS];
    logic [4:0]        hour_d     [NUM_ALARMS];
    logic [5:0]        min_q      [NUM_ALARMS];
    logic [5:0]        min_d      [NUM_ALARMS];
    logic [RING_W-1:0] ring_cnt_q [NUM_ALARMS];
    logic [RING_W-1:0] ring_cnt_d [NUM_ALARMS];
    logic [SNZ_W-1:0]  snz_cnt_q  [NUM_ALARMS];
    logic [SNZ_W-1:0]  snz_cnt_d  [NUM_ALARMS];
`ifdef ALARM_WEEKDAY_MASK_EN
    logic [6:0]        dow_mask_q [NUM_ALARMS];
    logic [6:0]        dow_mask_d [NUM_ALARMS];
`endif

    logic [NUM_ALARMS-1:0] ring_q, ring_d;
    logic                  alarm_any_q, alarm_any_d;
    logic [IDX_W-1:0]      active_idx_q, active_idx_d;
    logic                  wr_err_q, wr_err_d;
    logic                  wr_bad, wr_ok, sel, match;

    // Next-state for every channel; a valid write to a channel overrides all other events.
    always_comb begin
        wr_bad = wr_en && ((wr_hour > 5'd23) || (wr_min > 6'd59) || (32'(wr_idx) >= NUM_ALARMS));
        wr_ok  = wr_en && !wr_bad;
        sel    = 1'b0;
        match  = 1'b0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i]    = state_q[i];
            hour_d[i]     = hour_q[i];
            min_d[i]      = min_q[i];
            ring_cnt_d[i] = ring_cnt_q[i];
            snz_cnt_d[i]  = snz_cnt_q[i];
`ifdef ALARM_WEEKDAY_MASK_EN
            dow_mask_d[i] = dow_mask_q[i];
`endif
            sel   = (active_idx_q == IDX_W'(i));
            match = tick && (cur_sec == 6'd0) && (cur_hour == hour_q[i]) && (cur_min == min_q[i]);
`ifdef ALARM_WEEKDAY_MASK_EN
            match = match && (cur_dow <= 3'd6) && dow_mask_q[i][cur_dow];
`endif
            case (state_q[i])
                ST_ARMED: begin
                    if (match) begin
                        state_d[i]    = ST_RINGING;
                        ring_cnt_d[i] = '0;
                    end
                end
                ST_RINGING: begin
                    if (sel && ack) begin
                        state_d[i]    = ST_ARMED;
                        ring_cnt_d[i] = '0;
                    end else if (sel && snooze) begin
                        state_d[i]    = ST_SNOOZE;
                        ring_cnt_d[i] = '0;
                        snz_cnt_d[i]  = SNZ_LOAD;
                    end else if (tick) begin
                        if (ring_cnt_q[i] == RING_LAST) begin
                            state_d[i]    = ST_ARMED;
                            ring_cnt_d[i] = '0;
                        end else begin
                            ring_cnt_d[i] = ring_cnt_q[i] + RING_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (tick) begin
                        if (snz_cnt_q[i] == '0) begin
                            state_d[i]    = ST_RINGING;
                            ring_cnt_d[i] = '0;
                        end else begin
                            snz_cnt_d[i] = snz_cnt_q[i] - SNZ_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (wr_ok && (wr_idx == IDX_W'(i))) begin
                state_d[i]    = wr_arm ? ST_ARMED : ST_IDLE;
                hour_d[i]     = wr_hour;
                min_d[i]      = wr_min;
                ring_cnt_d[i] = '0;
                snz_cnt_d[i]  = '0;
`ifdef ALARM_WEEKDAY_MASK_EN
                dow_mask_d[i] = wr_dow_mask;
`endif
            end
            ring_d[i] = (state_d[i] == ST_RINGING);
        end
        // Lowest-index ringing channel wins: scan from the top so lower indices overwrite.
        active_idx_d = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_d[i]) active_idx_d = IDX_W'(i);
        end
        alarm_any_d = |ring_d;
        wr_err_d    = wr_bad;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= ST_IDLE;
                hour_q[i]     <= '0;
                min_q[i]      <= '0;
                ring_cnt_q[i] <= '0;
                snz_cnt_q[i]  <= '0;
`ifdef ALARM_WEEKDAY_MASK_EN
                dow_mask_q[i] <= '0;
`endif
            end
            ring_q       <= '0;
            alarm_any_q  <= 1'b0;
            active_idx_q <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i]    <= state_d[i];
                hour_q[i]     <= hour_d[i];
                min_q[i]      <= min_d[i];
                ring_cnt_q[i] <= ring_cnt_d[i];
                snz_cnt_q[i]  <= snz_cnt_d[i];
`ifdef ALARM_WEEKDAY_MASK_EN
                dow_mask_q[i] <= dow_mask_d[i];
`endif
            end
            ring_q       <= ring_d;
            alarm_any_q  <= alarm_any_d;
            active_idx_q <= active_idx_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign ring       = ring_q;
    assign alarm_any  = alarm_any_q;
    assign active_idx = active_idx_q;
    assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl (4 channels, RING_SEC=3, SNOOZE_MIN=1).
module tb_multi_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [4:0] wr_hour;
    logic [5:0] wr_min;
    logic       wr_arm;
    logic       ack;
    logic       snooze;
    logic [3:0] ring;
    logic       alarm_any;
    logic [1:0] active_idx;
    logic       wr_err;
`ifdef ALARM_WEEKDAY_MASK_EN
    logic [2:0] cur_dow     = 3'd0;
    logic [6:0] wr_dow_mask = 7'h7f;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    multi_alarm_ctrl #(.NUM_ALARMS(4), .RING_SEC(3), .SNOOZE_MIN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
`ifdef ALARM_WEEKDAY_MASK_EN
        .cur_dow    (cur_dow),
        .wr_dow_mask(wr_dow_mask),
`endif
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_hour    (wr_hour),
        .wr_min     (wr_min),
        .wr_arm     (wr_arm),
        .ack        (ack),
        .snooze     (snooze),
        .ring       (ring),
        .alarm_any  (alarm_any),
        .active_idx (active_idx),
        .wr_err     (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tk;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       we;
        logic [1:0] wi;
        logic [4:0] wh;
        logic [5:0] wm;
        logic       wa;
        logic       ak;
        logic       sn;
        logic [3:0] e_ring;
        logic       e_any;
        logic [1:0] e_idx;
        logic       e_err;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic tk, input int h, input int m, input int s,
                                input logic we, input int wi, input int wh, input int wm,
                                input logic wa, input logic ak, input logic sn,
                                input logic [3:0] er, input logic ea, input int ei, input logic ee);
        vec_t v;
        v.tk = tk; v.h = 5'(h); v.m = 6'(m); v.s = 6'(s);
        v.we = we; v.wi = 2'(wi); v.wh = 5'(wh); v.wm = 6'(wm); v.wa = wa;
        v.ak = ak; v.sn = sn;
        v.e_ring = er; v.e_any = ea; v.e_idx = 2'(ei); v.e_err = ee;
        return v;
    endfunction

    task automatic drv(input logic tk, input int h, input int m, input int s,
                       input logic we, input int wi, input int wh, input int wm,
                       input logic wa, input logic ak, input logic sn);
        tick = tk; cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
        wr_en = we; wr_idx = 2'(wi); wr_hour = 5'(wh); wr_min = 6'(wm); wr_arm = wa;
        ack = ak; snooze = sn;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] er, input logic ea,
                           input int ei, input logic ee);
        chk({nm, ".ring"},       int'(ring),       int'(er));
        chk({nm, ".alarm_any"},  int'(alarm_any),  int'(ea));
        chk({nm, ".active_idx"}, int'(active_idx), ei);
        chk({nm, ".wr_err"},     int'(wr_err),     int'(ee));
    endtask

    initial begin
        // tk  h  m  s  we wi wh wm wa ak sn | ring any idx err
        vecs[0]  = mk(0,  0,  0,  1, 1, 0,  7, 30, 1, 0, 0, 4'b0000, 0, 0, 0);
        vecs[1]  = mk(1,  7, 29, 59, 0, 0,  0,  0, 0, 0, 0, 4'b0000, 0, 0, 0);
        vecs[2]  = mk(1,  7, 30,  0, 0, 0,  0,  0, 0, 0, 0, 4'b0001, 1, 0, 0);
        vecs[3]  = mk(0,  7, 30,  0, 0, 0,  0,  0, 0, 0, 0, 4'b0001, 1, 0, 0);
        vecs[4]  = mk(0,  7, 30,  0, 0, 0,  0,  0, 0, 1, 0, 4'b0000, 0, 0, 0);
        vecs[5]  = mk(1,  7, 30,  0, 0, 0,  0,  0, 0, 0, 0, 4'b0001, 1, 0, 0);
        vecs[6]  = mk(0,  7, 30,  0, 0, 0,  0,  0, 0, 1, 0, 4'b0000, 0, 0, 0);
        vecs[7]  = mk(0,  0,  0,  1, 1, 1, 12,  0, 1, 0, 0, 4'b0000, 0, 0, 0);
        vecs[8]  = mk(0,  0,  0,  1, 1, 3, 12,  0, 1, 0, 0, 4'b0000, 0, 0, 0);
        vecs[9]  = mk(1, 12,  0,  0, 0, 0,  0,  0, 0, 0, 0, 4'b1010, 1, 1, 0);
        vecs[10] = mk(0, 12,  0,  0, 0, 0,  0,  0, 0, 1, 0, 4'b1000, 1, 3, 0);
        vecs[11] = mk(0, 12,  0,  0, 0, 0,  0,  0, 0, 1, 0, 4'b0000, 0, 0, 0);
        vecs[12] = mk(0,  0,  0,  1, 1, 0, 24,  0, 0, 0, 0, 4'b0000, 0, 0, 1);
        vecs[13] = mk(0,  0,  0,  1, 0, 0,  0,  0, 0, 0, 0, 4'b0000, 0, 0, 0);
        vecs[14] = mk(1,  7, 30,  0, 0, 0,  0,  0, 0, 0, 0, 4'b0001, 1, 0, 0);
        vecs[15] = mk(0,  7, 30,  0, 0, 0,  0,  0, 0, 1, 0, 4'b0000, 0, 0, 0);
        vecs[16] = mk(1,  7, 30,  0, 1, 0,  7, 30, 1, 0, 0, 4'b0000, 0, 0, 0);
        vecs[17] = mk(0,  0,  0,  1, 1, 2, 10, 60, 1, 0, 0, 4'b0000, 0, 0, 1);
        vecs[18] = mk(1, 10,  0,  0, 0, 0,  0,  0, 0, 0, 0, 4'b0000, 0, 0, 0);

        rst_n = 1'b0;
        idle();
        cyc();
        cyc();
        chk_out("reset", 4'b0000, 1'b0, 0, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drv(vecs[i].tk, int'(vecs[i].h), int'(vecs[i].m), int'(vecs[i].s),
                vecs[i].we, int'(vecs[i].wi), int'(vecs[i].wh), int'(vecs[i].wm),
                vecs[i].wa, vecs[i].ak, vecs[i].sn);
            cyc();
            chk_out($sformatf("vec%0d", i), vecs[i].e_ring, vecs[i].e_any,
                    int'(vecs[i].e_idx), vecs[i].e_err);
        end

        // Ring timeout: channel 2 clears on the third tick after the trigger
        drv(0, 0, 0, 1, 1, 2, 8, 0, 1, 0, 0); cyc();
        drv(1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk_out("timeout.fire", 4'b0100, 1'b1, 2, 1'b0);
        drv(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("timeout.t1", int'(ring), 4);
        drv(1, 8, 0, 2, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("timeout.t2", int'(ring), 4);
        drv(1, 8, 0, 3, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk_out("timeout.t3", 4'b0000, 1'b0, 0, 1'b0);

        // Snooze: ring returns on the 60th tick after snooze
        drv(0, 0, 0, 1, 1, 0, 6, 0, 1, 0, 0); cyc();
        drv(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("snooze.fire", int'(ring), 1);
        drv(0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
        chk_out("snooze.quiet", 4'b0000, 1'b0, 0, 1'b0);
        for (int k = 0; k < 59; k++) begin
            drv(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
        end
        chk("snooze.t59", int'(ring), 0);
        drv(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk_out("snooze.t60", 4'b0001, 1'b1, 0, 1'b0);
        drv(0, 6, 1, 1, 0, 0, 0, 0, 0, 1, 0); cyc();
        chk("snooze.ack", int'(ring), 0);

        // ack and snooze together: ack wins, so no re-ring 60 ticks later
        drv(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("both.fire", int'(ring), 1);
        drv(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc();
        chk("both.off", int'(ring), 0);
        for (int k = 0; k < 61; k++) begin
            drv(1, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc();
        end
        chk("both.no_resnooze", int'(ring), 0);
        drv(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("both.armed", int'(ring), 1);
        drv(0, 6, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();

        // Reset mid-ring cancels everything and leaves channels IDLE
        drv(0, 0, 0, 1, 1, 1, 9, 15, 1, 0, 0); cyc();
        drv(1, 9, 15, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk_out("rst.fire", 4'b0010, 1'b1, 1, 1'b0);
        idle();
        rst_n = 1'b0;
        cyc();
        chk_out("rst.edge1", 4'b0000, 1'b0, 0, 1'b0);
        cyc();
        rst_n = 1'b1;
        drv(1, 9, 15, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk_out("rst.silent", 4'b0000, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
